// File: rtl/clock_gating_ctrl_pkg.sv
// Shared definitions for the clock gating controller: channel FSM encoding,
// statistics counter width and a saturating increment helper.
// Optional feature macro: CLK_GATE_STAT_EN (per-channel gated-cycle statistics).
package clock_gating_ctrl_pkg;

  typedef enum logic [1:0] {
    CG_RUN   = 2'd0,
    CG_COUNT = 2'd1,
    CG_GATED = 2'd2,
    CG_WAKE  = 2'd3
  } cg_state_e;

  localparam int CG_STAT_W = 32;

  // Saturating increment for the statistics counters (never wraps to zero)
  function automatic logic [CG_STAT_W-1:0] cg_sat_inc(input logic [CG_STAT_W-1:0] v);
    logic [CG_STAT_W-1:0] r;
    if (v == {CG_STAT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/clock_gating_ch.sv
// One gated-clock channel: idle counter, RUN/COUNT/GATED/WAKE FSM, wake
// handshake and the clock gate cell. The enable fed to the gate is a
// registered decode of the next state, so it never glitches.
// Optional feature macro: CLK_GATE_STAT_EN adds a gated-cycle counter.
module clock_gating_ch
  import clock_gating_ctrl_pkg::*;
#(
  parameter int IDLE_CNT_W  = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  te,
  input  logic                  gate_en,
  input  logic [IDLE_CNT_W-1:0] idle_thresh,
  input  logic                  busy,
  input  logic                  force_on,
  input  logic                  wake_req,
`ifdef CLK_GATE_STAT_EN
  input  logic                  stat_clr,
  output logic [CG_STAT_W-1:0]  gated_cycles,
`endif
  output logic                  wake_ack,
  output logic                  gated,
  output logic                  clk_out
);

  localparam int WCNT_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [WCNT_W-1:0] WAKE_LAST = WCNT_W'(WAKE_CYCLES - 1);
  localparam logic [IDLE_CNT_W-1:0] CNT_MAX = {IDLE_CNT_W{1'b1}};
  localparam logic [IDLE_CNT_W-1:0] CNT_ZERO = {IDLE_CNT_W{1'b0}};
  localparam logic [IDLE_CNT_W-1:0] CNT_ONE = IDLE_CNT_W'(1);
  localparam logic [WCNT_W-1:0] WCNT_ZERO = {WCNT_W{1'b0}};
  localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

  cg_state_e             state_r, state_s;
  logic [IDLE_CNT_W-1:0] cnt_r, cnt_s;
  logic [WCNT_W-1:0]     wcnt_r, wcnt_s;
  logic                  ack_r, ack_s;
  logic                  en_r;
  logic                  gated_r;
  logic                  stop_s;
  logic                  thresh_zero_s;

  // Any reason the channel must keep (or regain) its clock
  assign stop_s        = busy | force_on | wake_req | ~gate_en;
  assign thresh_zero_s = (idle_thresh == CNT_ZERO);

  // Next-state, counter and acknowledge decode
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    wcnt_s  = wcnt_r;
    ack_s   = 1'b0;
    case (state_r)
      CG_RUN: begin
        // clock already running: acknowledge a request once
        ack_s = wake_req & ~ack_r;
        if (!stop_s && !thresh_zero_s) begin
          state_s = CG_COUNT;
          cnt_s   = CNT_ONE;
        end else begin
          cnt_s   = CNT_ZERO;
        end
      end
      CG_COUNT: begin
        ack_s = wake_req & ~ack_r;
        // activity beats a simultaneous threshold hit
        if (stop_s || thresh_zero_s) begin
          state_s = CG_RUN;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r >= idle_thresh) begin
          state_s = CG_GATED;
        end else if (cnt_r == CNT_MAX) begin
          cnt_s   = cnt_r;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      CG_GATED: begin
        if (stop_s) begin
          state_s = CG_WAKE;
          wcnt_s  = WCNT_ZERO;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = CG_GATED;
        end
      end
      CG_WAKE: begin
        // requests arriving during the settle window are merged into one ack
        if (wcnt_r == WAKE_LAST) begin
          state_s = CG_RUN;
          ack_s   = wake_req;
        end else begin
          wcnt_s  = wcnt_r + WCNT_ONE;
        end
      end
      default: begin
        state_s = CG_RUN;
        cnt_s   = CNT_ZERO;
        wcnt_s  = WCNT_ZERO;
      end
    endcase
  end

  // State, counters and registered outputs; enable is decoded from next state
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_r <= CG_RUN;
      cnt_r   <= CNT_ZERO;
      wcnt_r  <= WCNT_ZERO;
      ack_r   <= 1'b0;
      en_r    <= 1'b1;
      gated_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      wcnt_r  <= wcnt_s;
      ack_r   <= ack_s;
      en_r    <= (state_s != CG_GATED);
      gated_r <= (state_s == CG_GATED);
    end
  end

`ifdef CLK_GATE_STAT_EN
  logic [CG_STAT_W-1:0] stat_r;

  // Count cycles spent gated; clear has priority over increment
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      stat_r <= {CG_STAT_W{1'b0}};
    end else if (stat_clr) begin
      stat_r <= {CG_STAT_W{1'b0}};
    end else if (state_r == CG_GATED) begin
      stat_r <= cg_sat_inc(stat_r);
    end else begin
      stat_r <= stat_r;
    end
  end

  assign gated_cycles = stat_r;
`endif

  assign wake_ack = ack_r;
  assign gated    = gated_r;

  gated_clock_wrapper u_cg (
    .clk  (clk),
    .en   (en_r),
    .te   (te),
    .gclk (clk_out)
  );

endmodule

// File: rtl/gated_clock_wrapper.sv
// Glitch-free clock gate: a transparent-low latch holds (en | te) stable
// across the high phase, and the gated clock is clk AND the latched enable.
// te bypasses the functional enable so scan/test always sees a running clock.
module gated_clock_wrapper (
  input  logic clk,
  input  logic en,
  input  logic te,
  output logic gclk
);

  logic en_latch_r;

  // Capture the enable only while clk is low so it cannot change mid-pulse
  always_latch begin
    if (!clk) begin
      en_latch_r <= en | te;
    end
  end

  assign gclk = clk & en_latch_r;

endmodule

// File: rtl/clock_gating_ctrl.sv
// Multi-channel clock gating controller: NUM_CH independent channels, each
// gating its own clock after a programmable idle period and ungating on
// activity or a wake request with a settled acknowledge.
// Optional feature macro: CLK_GATE_STAT_EN adds stat_clr and ch_gated_cycles.
module clock_gating_ctrl
  import clock_gating_ctrl_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int IDLE_CNT_W  = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  te,
  input  logic                  gate_en,
  input  logic [IDLE_CNT_W-1:0] idle_thresh,
  input  logic [NUM_CH-1:0]     ch_busy,
  input  logic [NUM_CH-1:0]     ch_force_on,
  input  logic [NUM_CH-1:0]     ch_wake_req,
`ifdef CLK_GATE_STAT_EN
  input  logic                  stat_clr,
  output logic [NUM_CH*CG_STAT_W-1:0] ch_gated_cycles,
`endif
  output logic [NUM_CH-1:0]     ch_wake_ack,
  output logic [NUM_CH-1:0]     ch_gated,
  output logic [NUM_CH-1:0]     clk_out
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_gating_ch #(
      .IDLE_CNT_W  (IDLE_CNT_W),
      .WAKE_CYCLES (WAKE_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst_b        (rst_b),
      .te           (te),
      .gate_en      (gate_en),
      .idle_thresh  (idle_thresh),
      .busy         (ch_busy[g]),
      .force_on     (ch_force_on[g]),
      .wake_req     (ch_wake_req[g]),
`ifdef CLK_GATE_STAT_EN
      .stat_clr     (stat_clr),
      .gated_cycles (ch_gated_cycles[g*CG_STAT_W +: CG_STAT_W]),
`endif
      .wake_ack     (ch_wake_ack[g]),
      .gated        (ch_gated[g]),
      .clk_out      (clk_out[g])
    );
  end

endmodule

// File: tb/tb_clock_gating_ctrl.sv
// Self-checking bench for clock_gating_ctrl (NUM_CH=4, IDLE_CNT_W=8, WAKE_CYCLES=2).
// Expected per-cycle outputs are queued when stimulus is applied and popped
// when the corresponding cycle is sampled on the falling clock edge.
// Define CLK_GATE_STAT_EN to also exercise the gated-cycle statistics.
module tb_clock_gating_ctrl;

  localparam int NUM_CH = 4;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        te;
  logic        gate_en;
  logic [7:0]  idle_thresh;
  logic [3:0]  ch_busy;
  logic [3:0]  ch_force_on;
  logic [3:0]  ch_wake_req;
  logic [3:0]  ch_wake_ack;
  logic [3:0]  ch_gated;
  logic [3:0]  clk_out;
`ifdef CLK_GATE_STAT_EN
  logic        stat_clr;
  logic [127:0] ch_gated_cycles;
`endif

  int passed = 0;
  int total  = 0;
  int e0     = 0;
  int glitch = 0;

  logic [3:0] exp_gated_q[$];
  logic [3:0] exp_ack_q[$];

  always #5 clk = ~clk;

  // count gated clock pulses on channel 0 and flag any pulse outside clk high
  always @(posedge clk_out[0]) begin
    e0 = e0 + 1;
    if (clk !== 1'b1) glitch = glitch + 1;
  end

  clock_gating_ctrl #(.NUM_CH(4), .IDLE_CNT_W(8), .WAKE_CYCLES(2)) dut (
    .clk             (clk),
    .rst_b           (rst_b),
    .te              (te),
    .gate_en         (gate_en),
    .idle_thresh     (idle_thresh),
    .ch_busy         (ch_busy),
    .ch_force_on     (ch_force_on),
    .ch_wake_req     (ch_wake_req),
`ifdef CLK_GATE_STAT_EN
    .stat_clr        (stat_clr),
    .ch_gated_cycles (ch_gated_cycles),
`endif
    .ch_wake_ack     (ch_wake_ack),
    .ch_gated        (ch_gated),
    .clk_out         (clk_out)
  );

  task automatic do_reset(input logic [7:0] th);
    rst_b = 1'b0; te = 1'b0; gate_en = 1'b1; idle_thresh = th;
    ch_busy = 4'h0; ch_force_on = 4'h0; ch_wake_req = 4'h0;
`ifdef CLK_GATE_STAT_EN
    stat_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_reset;
    int snap;
    logic [3:0] eg;
    rst_b = 1'b0; te = 1'b0; gate_en = 1'b1; idle_thresh = 8'd4;
    ch_busy = 4'h0; ch_force_on = 4'h0; ch_wake_req = 4'h0;
`ifdef CLK_GATE_STAT_EN
    stat_clr = 1'b0;
`endif
    @(negedge clk);
    snap = e0;
    repeat (2) @(negedge clk);
    total++; if (ch_gated !== 4'h0) $display("FAIL reset_gated got=%b exp=0000", ch_gated); else passed++;
    total++; if (ch_wake_ack !== 4'h0) $display("FAIL reset_ack got=%b exp=0000", ch_wake_ack); else passed++;
    total++; if (e0 - snap !== 2) $display("FAIL reset_clk_runs got=%0d exp=2", e0 - snap); else passed++;
    rst_b = 1'b1;
    for (int k = 1; k <= 7; k++) exp_gated_q.push_back((k >= 5) ? 4'hF : 4'h0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      eg = exp_gated_q.pop_front();
      total++; if (ch_gated !== eg) $display("FAIL idle_to_gate k=%0d got=%b exp=%b", k, ch_gated, eg); else passed++;
    end
    snap = e0;
    repeat (10) @(negedge clk);
    total++; if (e0 !== snap) $display("FAIL gated_clk_flat got=%0d exp=%0d", e0, snap); else passed++;
  endtask

  task automatic test_wake;
    int snap;
    logic [3:0] eg, ea;
    do_reset(8'd4);
    repeat (5) @(negedge clk);
    total++; if (ch_gated !== 4'hF) $display("FAIL wake_pre_gated got=%b exp=1111", ch_gated); else passed++;
    ch_wake_req = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      exp_ack_q.push_back((k == 3) ? 4'b0001 : 4'b0000);
      exp_gated_q.push_back(4'b1110);
    end
    snap = e0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      ea = exp_ack_q.pop_front();
      eg = exp_gated_q.pop_front();
      total++; if (ch_wake_ack !== ea) $display("FAIL wake_ack k=%0d got=%b exp=%b", k, ch_wake_ack, ea); else passed++;
      total++; if (ch_gated !== eg) $display("FAIL wake_gated k=%0d got=%b exp=%b", k, ch_gated, eg); else passed++;
      if (k == 1) snap = e0;
      if (k == 2) begin
        total++; if (e0 - snap !== 1) $display("FAIL wake_clk_resumes got=%0d exp=1", e0 - snap); else passed++;
      end
      if (k == 3) ch_wake_req = 4'b0000;
    end
  endtask

  task automatic test_wake_in_run;
    logic [3:0] ea;
    do_reset(8'd4);
    ch_force_on = 4'hF;
    @(negedge clk);
    ch_wake_req = 4'b0010;
    exp_ack_q.push_back(4'b0010);
    exp_ack_q.push_back(4'b0000);
    exp_ack_q.push_back(4'b0000);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      ea = exp_ack_q.pop_front();
      total++; if (ch_wake_ack !== ea) $display("FAIL run_ack k=%0d got=%b exp=%b", k, ch_wake_ack, ea); else passed++;
      ch_wake_req = 4'b0000;
    end
  endtask

  task automatic test_busy_on_thresh;
    int snap;
    logic [3:0] eg;
    do_reset(8'd3);
    for (int k = 1; k <= 7; k++) exp_gated_q.push_back((k >= 4) ? 4'b1110 : 4'b0000);
    snap = e0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      eg = exp_gated_q.pop_front();
      total++; if (ch_gated !== eg) $display("FAIL busy_thresh k=%0d got=%b exp=%b", k, ch_gated, eg); else passed++;
      if (k == 3) ch_busy = 4'b0001;
      if (k == 4) snap = e0;
    end
    total++; if (e0 - snap !== 3) $display("FAIL busy_clk_runs got=%0d exp=3", e0 - snap); else passed++;
  endtask

  task automatic test_no_gate;
    logic [3:0] eg;
    for (int c = 0; c < 3; c++) begin
      do_reset((c == 0) ? 8'd0 : 8'd4);
      if (c == 1) ch_force_on = 4'hF;
      if (c == 2) gate_en = 1'b0;
      for (int p = 0; p < 4; p++) begin
        exp_gated_q.push_back(4'h0);
        repeat (250) @(negedge clk);
        eg = exp_gated_q.pop_front();
        total++; if (ch_gated !== eg) $display("FAIL no_gate case=%0d p=%0d got=%b exp=%b", c, p, ch_gated, eg); else passed++;
      end
    end
    do_reset(8'd2);
    repeat (3) @(negedge clk);
    total++; if (ch_gated !== 4'hF) $display("FAIL gate_en_pre got=%b exp=1111", ch_gated); else passed++;
    gate_en = 1'b0;
    @(negedge clk);
    total++; if (ch_gated !== 4'h0) $display("FAIL gate_en_fall got=%b exp=0000", ch_gated); else passed++;
    total++; if (ch_wake_ack !== 4'h0) $display("FAIL gate_en_noack got=%b exp=0000", ch_wake_ack); else passed++;
  endtask

  task automatic test_te;
    int snap;
    do_reset(8'd2);
    repeat (3) @(negedge clk);
    total++; if (ch_gated !== 4'hF) $display("FAIL te_pre got=%b exp=1111", ch_gated); else passed++;
    te = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++; if (clk_out !== 4'hF) $display("FAIL te_high k=%0d got=%b exp=1111", k, clk_out); else passed++;
      @(negedge clk); #1;
      total++; if (clk_out !== 4'h0) $display("FAIL te_low k=%0d got=%b exp=0000", k, clk_out); else passed++;
      total++; if (ch_gated !== 4'hF) $display("FAIL te_gated k=%0d got=%b exp=1111", k, ch_gated); else passed++;
    end
    te = 1'b0;
    snap = e0;
    repeat (5) @(negedge clk);
    total++; if (e0 !== snap) $display("FAIL te_off_flat got=%0d exp=%0d", e0, snap); else passed++;
    total++; if (ch_gated !== 4'hF) $display("FAIL te_off_gated got=%b exp=1111", ch_gated); else passed++;
  endtask

  task automatic test_reset_mid_gate;
    int snap;
    do_reset(8'd2);
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    total++; if (ch_gated !== 4'h0) $display("FAIL midrst_gated got=%b exp=0000", ch_gated); else passed++;
    snap = e0;
    @(negedge clk);
    total++; if (e0 - snap !== 1) $display("FAIL midrst_clk got=%0d exp=1", e0 - snap); else passed++;
    rst_b = 1'b1;
  endtask

`ifdef CLK_GATE_STAT_EN
  task automatic test_stats;
    do_reset(8'd2);
    repeat (3) @(negedge clk);
    repeat (100) @(negedge clk);
    total++; if (ch_gated_cycles[31:0] !== 32'd100) $display("FAIL stat_100 got=%0d exp=100", ch_gated_cycles[31:0]); else passed++;
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    total++; if (ch_gated_cycles !== 128'd0) $display("FAIL stat_clr got=%h exp=0", ch_gated_cycles); else passed++;
    repeat (5) @(negedge clk);
    total++; if (ch_gated_cycles[63:32] !== 32'd5) $display("FAIL stat_5 got=%0d exp=5", ch_gated_cycles[63:32]); else passed++;
    rst_b = 1'b0;
    @(negedge clk);
    total++; if (ch_gated_cycles !== 128'd0) $display("FAIL stat_rst got=%h exp=0", ch_gated_cycles); else passed++;
    total++; if (ch_gated !== 4'h0) $display("FAIL stat_rst_gated got=%b exp=0000", ch_gated); else passed++;
    rst_b = 1'b1;
  endtask
`endif

  initial begin
    test_reset;
    test_wake;
    test_wake_in_run;
    test_busy_on_thresh;
    test_no_gate;
    test_te;
    test_reset_mid_gate;
`ifdef CLK_GATE_STAT_EN
    test_stats;
`endif
    total++; if (glitch !== 0) $display("FAIL clk_out_glitch got=%0d exp=0", glitch); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
